// File: rtl/hazard_pkg.sv
// hazard_pkg
//   Shared types and constants for the pipeline hazard controller.
//   - state_e : controller FSM states (RUN, LOAD_STALL, MD_BUSY)
//   - FWD_*   : execute-stage operand forward-select encodings
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MD_BUSY    = 2'd2
  } state_e;

  localparam logic [1:0] FWD_REG = 2'b00;  // register file value
  localparam logic [1:0] FWD_W   = 2'b01;  // ResultW
  localparam logic [1:0] FWD_M   = 2'b10;  // ALUResultM

endpackage

// File: rtl/hazard_fwd.sv
// hazard_fwd
//   Combinational forward select for one execute-stage source operand.
//   The memory stage wins over writeback because it holds the younger value.
//   A load in M has no ALU result yet, so it is never a forwarding source.
// Ports:
//   rs_e_i        execute-stage source register
//   rd_m_i        memory-stage destination
//   rd_w_i        writeback-stage destination
//   reg_write_m_i memory-stage write enable
//   reg_write_w_i writeback-stage write enable
//   mem_read_m_i  memory-stage instruction is a load
//   fwd_o         operand select (FWD_REG / FWD_W / FWD_M)
module hazard_fwd
  import hazard_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] rs_e_i,
  input  logic [ADDR_W-1:0] rd_m_i,
  input  logic [ADDR_W-1:0] rd_w_i,
  input  logic              reg_write_m_i,
  input  logic              reg_write_w_i,
  input  logic              mem_read_m_i,
  output logic [1:0]        fwd_o
);

  logic hit_m;
  logic hit_w;

  // x0 is hard-wired to zero, so a write to it must never be forwarded.
  assign hit_m = reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs_e_i) && !mem_read_m_i;
  assign hit_w = reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs_e_i);

  assign fwd_o = hit_m ? FWD_M : (hit_w ? FWD_W : FWD_REG);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Sequential hazard controller for the 5-stage RV32I pipeline.
//   Drives every stage register's stall/flush and the execute-stage
//   forwarding muxes. Handles multi-cycle load-use stalls, a mul/div busy
//   handshake, data-memory wait freezing and branch flushes, and keeps a
//   saturating count of stalled fetch cycles.
// Ports:
//   clk, rst                        clock, async active-high reset
//   Rs1D, Rs2D                      decode-stage sources
//   Rs1E, Rs2E, RdE                 execute-stage sources / destination
//   RdM, RdW, RegWriteM, RegWriteW  later-stage destinations and enables
//   MemReadE, MemReadM, MemWriteM   load/store flags
//   mem_ready                       data memory ready (low freezes on M access)
//   md_startE, md_done              mul/div handshake
//   flush_branch                    mispredict resolved in E
//   ForwardAE, ForwardBE            operand forward selects
//   StallF/D/E/M, FlushD/E/M/W      stage register hold / bubble controls
//   stall_cycles                    saturating count of StallF cycles
// All stall/flush/forward outputs are combinational (same-cycle response).
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] Rs1D,
  input  logic [ADDR_W-1:0] Rs2D,
  input  logic [ADDR_W-1:0] Rs1E,
  input  logic [ADDR_W-1:0] Rs2E,
  input  logic [ADDR_W-1:0] RdE,
  input  logic [ADDR_W-1:0] RdM,
  input  logic [ADDR_W-1:0] RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemReadE,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic              mem_ready,
  input  logic              md_startE,
  input  logic              md_done,
  input  logic              flush_branch,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              FlushW,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int LU_W = $clog2(LOAD_LAT + 1);

  state_e            state_q, state_d;
  logic [LU_W-1:0]   lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
  logic [1:0]        fwd_a, fwd_b;
  logic              freeze;
  logic              load_use;

  hazard_fwd #(.ADDR_W(ADDR_W)) u_fwd_a (
    .rs_e_i        (Rs1E),
    .rd_m_i        (RdM),
    .rd_w_i        (RdW),
    .reg_write_m_i (RegWriteM),
    .reg_write_w_i (RegWriteW),
    .mem_read_m_i  (MemReadM),
    .fwd_o         (fwd_a)
  );

  hazard_fwd #(.ADDR_W(ADDR_W)) u_fwd_b (
    .rs_e_i        (Rs2E),
    .rd_m_i        (RdM),
    .rd_w_i        (RdW),
    .reg_write_m_i (RegWriteM),
    .reg_write_w_i (RegWriteW),
    .mem_read_m_i  (MemReadM),
    .fwd_o         (fwd_b)
  );

  // Outputs are forced idle while reset is held, so a reset mid-stall
  // releases the pipeline in the same cycle.
  assign ForwardAE = rst ? FWD_REG : fwd_a;
  assign ForwardBE = rst ? FWD_REG : fwd_b;

  assign freeze   = !mem_ready && (MemReadM || MemWriteM);
  assign load_use = MemReadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

  assign stall_cycles = stall_cycles_q;

  // Priority encoder: rst > freeze > flush_branch > MD_BUSY > load-use.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d  = state_q;
    lu_cnt_d = lu_cnt_q;
    StallF   = 1'b0;
    StallD   = 1'b0;
    StallE   = 1'b0;
    StallM   = 1'b0;
    FlushD   = 1'b0;
    FlushE   = 1'b0;
    FlushM   = 1'b0;
    FlushW   = 1'b0;

    if (rst) begin
      // defaults already describe the idle reset response
    end else if (freeze) begin
      // Whole front of the pipe waits on memory; W drains as a bubble.
      // State and lu_cnt hold, so a frozen cycle never counts toward a stall.
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (flush_branch) begin
      // Squashes the wrong-path D/E instructions, including a stalled consumer.
      FlushD   = 1'b1;
      FlushE   = 1'b1;
      state_d  = RUN;
      lu_cnt_d = '0;
    end else begin
      case (state_q)
        MD_BUSY: begin
          if (!md_done) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            FlushM = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
        LOAD_STALL: begin
          StallF   = 1'b1;
          StallD   = 1'b1;
          FlushE   = 1'b1;
          lu_cnt_d = lu_cnt_q - LU_W'(1);
          if (lu_cnt_q == LU_W'(1)) state_d = RUN;
        end
        default: begin  // RUN
          if (md_startE && !md_done) begin
            StallF  = 1'b1;
            StallD  = 1'b1;
            StallE  = 1'b1;
            FlushM  = 1'b1;
            state_d = MD_BUSY;
          end else if (load_use) begin
            // The first stall cycle is spent here in RUN; LOAD_STALL covers the rest.
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d  = LOAD_STALL;
              lu_cnt_d = LU_W'(LOAD_LAT - 1);
            end
          end
        end
      endcase
    end

    stall_cycles_d = (StallF && (stall_cycles_q != '1)) ? stall_cycles_q + CNT_W'(1)
                                                        : stall_cycles_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= RUN;
      lu_cnt_q       <= '0;
      stall_cycles_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples its pre-edge value regardless of statement order.
      state_q        <= state_d;
      lu_cnt_q       <= lu_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // The md op occupies E while busy, so a branch resolving in E is impossible.
  a_no_branch_in_md_busy: assert property (
    @(posedge clk) disable iff (rst) !(state_q == MD_BUSY && flush_branch)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int ADDR_W   = 5;
  localparam int LOAD_LAT = 3;
  localparam int CNT_W    = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic              RegWriteM, RegWriteW, MemReadE, MemReadM, MemWriteM;
  logic              mem_ready, md_startE, md_done, flush_branch;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              StallF, StallD, StallE, StallM;
  logic              FlushD, FlushE, FlushM, FlushW;
  logic [CNT_W-1:0]  stall_cycles;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_ctrl #(.ADDR_W(ADDR_W), .LOAD_LAT(LOAD_LAT), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .Rs1D         (Rs1D),
    .Rs2D         (Rs2D),
    .Rs1E         (Rs1E),
    .Rs2E         (Rs2E),
    .RdE          (RdE),
    .RdM          (RdM),
    .RdW          (RdW),
    .RegWriteM    (RegWriteM),
    .RegWriteW    (RegWriteW),
    .MemReadE     (MemReadE),
    .MemReadM     (MemReadM),
    .MemWriteM    (MemWriteM),
    .mem_ready    (mem_ready),
    .md_startE    (md_startE),
    .md_done      (md_done),
    .flush_branch (flush_branch),
    .ForwardAE    (ForwardAE),
    .ForwardBE    (ForwardBE),
    .StallF       (StallF),
    .StallD       (StallD),
    .StallE       (StallE),
    .StallM       (StallM),
    .FlushD       (FlushD),
    .FlushE       (FlushE),
    .FlushM       (FlushM),
    .FlushW       (FlushW),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] stalls();
    return {StallF, StallD, StallE, StallM};
  endfunction

  function automatic logic [3:0] flushes();
    return {FlushD, FlushE, FlushM, FlushW};
  endfunction

  task automatic idle();
    rst = 1'b0;
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    RegWriteM = 1'b0; RegWriteW = 1'b0;
    MemReadE = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0;
    mem_ready = 1'b1; md_startE = 1'b0; md_done = 1'b0; flush_branch = 1'b0;
  endtask

  // Called at a negedge with stimulus applied: checks this cycle's outputs,
  // clocks one edge, returns at the next negedge.
  task automatic cyc(input string name, input logic [3:0] exp_stall, input logic [3:0] exp_flush);
    #2;
    check({name, ".stall"}, 32'(stalls()), 32'(exp_stall));
    check({name, ".flush"}, 32'(flushes()), 32'(exp_flush));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    #2;
    check("reset.outs", {20'd0, ForwardAE, ForwardBE, stalls(), flushes()}, 32'd0);
    check("reset.cnt", 32'(stall_cycles), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Reference forwarding rule, written directly from the operand-priority rules.
  function automatic logic [1:0] fwd_ref(input int rs, input int rdm, input int rdw,
                                         input bit rwm, input bit rww, input bit mrm);
    if (rwm && rdm != 0 && rdm == rs && !mrm) return 2'b10;
    if (rww && rdw != 0 && rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  typedef struct {
    logic [ADDR_W-1:0] rs1e, rs2e, rdm, rdw;
    logic              rwm, rww, mrm;
    logic [1:0]        exp_a, exp_b;
  } fwd_vec_t;

  fwd_vec_t vecs[7];

  // Behavioural model state: outstanding load-stall cycles and mul/div wait.
  int ld_rem;
  bit md_wait;
  int cnt;

  initial begin
    vecs[0] = '{5'd5, 5'd9, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 2'b10, 2'b00};
    vecs[1] = '{5'd5, 5'd9, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 2'b01, 2'b00};
    vecs[2] = '{5'd5, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00};
    vecs[3] = '{5'd5, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 2'b01, 2'b01};
    vecs[4] = '{5'd3, 5'd4, 5'd4, 5'd3, 1'b1, 1'b1, 1'b0, 2'b01, 2'b10};
    vecs[5] = '{5'd3, 5'd4, 5'd3, 5'd4, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    vecs[6] = '{5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00};

    idle();
    @(negedge clk);
    do_reset();

    // Forwarding table
    for (int i = 0; i < 7; i++) begin
      idle();
      Rs1E = vecs[i].rs1e; Rs2E = vecs[i].rs2e; RdM = vecs[i].rdm; RdW = vecs[i].rdw;
      RegWriteM = vecs[i].rwm; RegWriteW = vecs[i].rww; MemReadM = vecs[i].mrm;
      #2;
      check($sformatf("fwd[%0d].A", i), 32'(ForwardAE), 32'(vecs[i].exp_a));
      check($sformatf("fwd[%0d].B", i), 32'(ForwardBE), 32'(vecs[i].exp_b));
      @(negedge clk);
    end

    // Load-use: exactly LOAD_LAT stall cycles
    do_reset();
    Rs2D = 5'd7; RdE = 5'd7; MemReadE = 1'b1;
    cyc("lu0", 4'b1100, 4'b0100);
    MemReadE = 1'b0; RdE = '0;
    cyc("lu1", 4'b1100, 4'b0100);
    cyc("lu2", 4'b1100, 4'b0100);
    cyc("lu3", 4'b0000, 4'b0000);
    check("lu.cnt", 32'(stall_cycles), 32'd3);

    // Load-use with branch in same cycle: branch wins, stays in RUN
    do_reset();
    Rs1D = 5'd6; RdE = 5'd6; MemReadE = 1'b1; flush_branch = 1'b1;
    cyc("lubr0", 4'b0000, 4'b1100);
    idle();
    cyc("lubr1", 4'b0000, 4'b0000);
    check("lubr.cnt", 32'(stall_cycles), 32'd0);

    // Branch during LOAD_STALL aborts the stall
    do_reset();
    Rs1D = 5'd6; RdE = 5'd6; MemReadE = 1'b1;
    cyc("lsbr0", 4'b1100, 4'b0100);
    idle(); flush_branch = 1'b1;
    cyc("lsbr1", 4'b0000, 4'b1100);
    flush_branch = 1'b0;
    cyc("lsbr2", 4'b0000, 4'b0000);

    // Mul/div busy for 4 cycles, released in the md_done cycle
    do_reset();
    md_startE = 1'b1;
    for (int i = 0; i < 4; i++) cyc($sformatf("md%0d", i), 4'b1110, 4'b0010);
    md_done = 1'b1;
    cyc("md_done", 4'b0000, 4'b0000);
    idle();
    cyc("md_after", 4'b0000, 4'b0000);
    check("md.cnt", 32'(stall_cycles), 32'd4);
    md_startE = 1'b1; md_done = 1'b1;
    cyc("md_same", 4'b0000, 4'b0000);
    idle();
    cyc("md_same_after", 4'b0000, 4'b0000);

    // Freeze during LOAD_STALL holds lu_cnt; stall resumes afterwards
    do_reset();
    Rs2D = 5'd7; RdE = 5'd7; MemReadE = 1'b1;
    cyc("fz_lu0", 4'b1100, 4'b0100);
    MemReadE = 1'b0; RdE = '0; MemReadM = 1'b1; mem_ready = 1'b0;
    cyc("fz0", 4'b1111, 4'b0001);
    cyc("fz1", 4'b1111, 4'b0001);
    mem_ready = 1'b1;
    cyc("fz_res0", 4'b1100, 4'b0100);
    cyc("fz_res1", 4'b1100, 4'b0100);
    cyc("fz_end", 4'b0000, 4'b0000);
    check("fz.cnt", 32'(stall_cycles), 32'd5);

    // Branch held through a freeze takes effect in the first unfrozen cycle
    do_reset();
    MemWriteM = 1'b1; mem_ready = 1'b0; flush_branch = 1'b1;
    cyc("fzbr0", 4'b1111, 4'b0001);
    mem_ready = 1'b1;
    cyc("fzbr1", 4'b0000, 4'b1100);

    // Reset in the middle of MD_BUSY
    do_reset();
    md_startE = 1'b1;
    cyc("mdrst0", 4'b1110, 4'b0010);
    cyc("mdrst1", 4'b1110, 4'b0010);
    rst = 1'b1;
    #2;
    check("mdrst.outs", {20'd0, ForwardAE, ForwardBE, stalls(), flushes()}, 32'd0);
    check("mdrst.cnt", 32'(stall_cycles), 32'd0);
    @(negedge clk);
    idle();
    cyc("mdrst.run", 4'b0000, 4'b0000);

    // Counter saturation
    do_reset();
    md_startE = 1'b1;
    repeat (CNT_MAX + 5) @(negedge clk);
    check("sat.cnt", 32'(stall_cycles), 32'(CNT_MAX));
    md_done = 1'b1;
    cyc("sat.done", 4'b0000, 4'b0000);
    check("sat.hold", 32'(stall_cycles), 32'(CNT_MAX));

    // Randomised run against the behavioural model
    do_reset();
    ld_rem = 0; md_wait = 0; cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] es, ef;
      logic [1:0] ea, eb;
      bit frz, lu;
      rst          = ($urandom_range(99) == 0);
      Rs1D         = ADDR_W'($urandom_range(3));
      Rs2D         = ADDR_W'($urandom_range(3));
      Rs1E         = ADDR_W'($urandom_range(3));
      Rs2E         = ADDR_W'($urandom_range(3));
      RdE          = ADDR_W'($urandom_range(3));
      RdM          = ADDR_W'($urandom_range(3));
      RdW          = ADDR_W'($urandom_range(3));
      RegWriteM    = 1'($urandom_range(1));
      RegWriteW    = 1'($urandom_range(1));
      MemReadE     = ($urandom_range(2) == 0);
      MemReadM     = ($urandom_range(2) == 0);
      MemWriteM    = ($urandom_range(4) == 0);
      mem_ready    = ($urandom_range(3) != 0);
      md_startE    = ($urandom_range(5) == 0);
      md_done      = ($urandom_range(3) == 0);
      flush_branch = !md_wait && ($urandom_range(7) == 0);
      #2;
      frz = !mem_ready && (MemReadM || MemWriteM);
      lu  = MemReadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
      ea = rst ? 2'b00 : fwd_ref(int'(Rs1E), int'(RdM), int'(RdW), RegWriteM, RegWriteW, MemReadM);
      eb = rst ? 2'b00 : fwd_ref(int'(Rs2E), int'(RdM), int'(RdW), RegWriteM, RegWriteW, MemReadM);
      es = 4'b0000; ef = 4'b0000;
      if (rst) begin
      end else if (frz) begin
        es = 4'b1111; ef = 4'b0001;
      end else if (flush_branch) begin
        ef = 4'b1100;
      end else if (md_wait) begin
        if (!md_done) begin es = 4'b1110; ef = 4'b0010; end
      end else if (ld_rem > 0) begin
        es = 4'b1100; ef = 4'b0100;
      end else if (md_startE && !md_done) begin
        es = 4'b1110; ef = 4'b0010;
      end else if (lu) begin
        es = 4'b1100; ef = 4'b0100;
      end
      check($sformatf("rand[%0d].outs", i), {20'd0, ForwardAE, ForwardBE, stalls(), flushes()},
            {20'd0, ea, eb, es, ef});
      @(posedge clk);
      if (rst) begin
        ld_rem = 0; md_wait = 0; cnt = 0;
      end else begin
        if (es[3] && cnt < CNT_MAX) cnt++;
        if (!frz) begin
          if (flush_branch) begin
            ld_rem = 0; md_wait = 0;
          end else if (md_wait) begin
            if (md_done) md_wait = 0;
          end else if (ld_rem > 0) begin
            ld_rem--;
          end else if (md_startE && !md_done) begin
            md_wait = 1;
          end else if (lu) begin
            ld_rem = LOAD_LAT - 1;
          end
        end
      end
      #1;
      check($sformatf("rand[%0d].cnt", i), 32'(stall_cycles), 32'(cnt));
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
